// File: rtl/uart8n1_pkg.sv
// -----------------------------------------------------------------------------
// uart8n1_pkg
// Shared definitions for the 8N1 UART core: the state encoding used by both
// the TX and RX state machines, the data width and the default clock and
// baud-rate values.
// -----------------------------------------------------------------------------
package uart8n1_pkg;

  localparam int DATA_BITS        = 8;
  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 115200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart8n1_if.sv
// -----------------------------------------------------------------------------
// uart8n1_if
// Parallel-side bus of the UART core.
//   tx_start / tx_data : transmit request and byte (master -> core)
//   tx_busy / tx_done  : transmit status (core -> master)
//   rx_busy / rx_done  : receive status (core -> master)
//   rx_data            : last correctly received byte (core -> master)
//   rx_frame_err       : stop-bit error pulse, only with UART_FRAME_ERR_EN
// Modports: master (system side), slave (the UART core).
// -----------------------------------------------------------------------------
interface uart8n1_if;
  import uart8n1_pkg::*;

  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 rx_busy;
  logic                 rx_done;
  logic [DATA_BITS-1:0] rx_data;
`ifdef UART_FRAME_ERR_EN
  logic                 rx_frame_err;

  modport master (output tx_start, tx_data,
                  input  tx_busy, tx_done, rx_busy, rx_done, rx_data, rx_frame_err);
  modport slave  (input  tx_start, tx_data,
                  output tx_busy, tx_done, rx_busy, rx_done, rx_data, rx_frame_err);
`else
  modport master (output tx_start, tx_data,
                  input  tx_busy, tx_done, rx_busy, rx_done, rx_data);
  modport slave  (input  tx_start, tx_data,
                  output tx_busy, tx_done, rx_busy, rx_done, rx_data);
`endif

endinterface

// File: rtl/uart8n1_rx.sv
// -----------------------------------------------------------------------------
// uart8n1_rx
// 8N1 receiver: two-flop synchroniser on rx_line followed by the RX FSM
// (IDLE, START, DATA, STOP). Bits are sampled mid-bit; the FSM returns to IDLE
// at the middle of the stop bit so back-to-back frames are accepted.
// Ports:
//   clk, reset (async, active low), en (core enable)
//   rx_line      : serial input, asynchronous to clk
//   rx_busy      : frame in progress
//   rx_done      : one-cycle pulse, rx_data just updated
//   rx_data      : last correctly received byte
//   rx_frame_err : one-cycle pulse on a 0 stop bit (UART_FRAME_ERR_EN only)
// -----------------------------------------------------------------------------
module uart8n1_rx
  import uart8n1_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 rx_line,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] rx_data
`ifdef UART_FRAME_ERR_EN
  ,
  output logic                 rx_frame_err
`endif
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  uart_state_e          state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 bit_end, half_end;
  logic                 sample_bit, stop_end;
  logic                 done_q;
`ifdef UART_FRAME_ERR_EN
  logic                 err_q;
`endif

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_line};
  end

  assign rx_s     = sync_q[1];
  assign bit_end  = (cnt == BIT_LAST);
  assign half_end = (cnt == HALF_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // START waits half a bit and re-checks the line to reject short glitches.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (!rx_s) state_next = START;
        START:   if (half_end) state_next = rx_s ? IDLE : DATA;
        DATA:    if (bit_end && bit_idx == 3'd7) state_next = STOP;
        STOP:    if (bit_end) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy    = 1'b0;
    sample_bit = 1'b0;
    stop_end   = 1'b0;
    if (en) begin
      rx_busy    = (state != IDLE);
      sample_bit = (state == DATA) && bit_end;
      stop_end   = (state == STOP) && bit_end;
    end
  end

  // The START half-bit wait leaves cnt at zero on entry to DATA, so every
  // later BIT_LAST lands in the middle of a bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (!en || state == IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if ((state == START && half_end) || bit_end) cnt <= '0;
      else                                         cnt <= cnt + 1'b1;
      if (sample_bit && bit_idx != 3'd7) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      rx_data <= '0;
      done_q  <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= stop_end && rx_s;
`ifdef UART_FRAME_ERR_EN
      err_q  <= stop_end && !rx_s;
`endif
      if (sample_bit)         shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      if (stop_end && rx_s)   rx_data <= shift_q;
    end
  end

  assign rx_done = done_q && en;
`ifdef UART_FRAME_ERR_EN
  assign rx_frame_err = err_q && en;
`endif

endmodule

// File: rtl/uart8n1_top.sv
// -----------------------------------------------------------------------------
// uart8n1_top
// Full-duplex 8N1 UART core: inline TX FSM plus the uart8n1_rx receiver.
// Parameters: CLK_FREQ (Hz), BAUD; CLKS_PER_BIT = CLK_FREQ/BAUD, must be >= 4.
// Ports:
//   clk, reset (async, active low), en (core enable, TX and RX run only when 1)
//   bus     : uart8n1_if.slave parallel side (tx_start/tx_data in,
//             tx_busy/tx_done/rx_busy/rx_done/rx_data out)
//   tx_line : serial output, idles high
//   rx_line : serial input
// Optional: define UART_FRAME_ERR_EN to add bus.rx_frame_err.
// -----------------------------------------------------------------------------
module uart8n1_top
  import uart8n1_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  uart8n1_if.slave  bus,
  output logic      tx_line,
  input  logic      rx_line
);

  localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart8n1_top: CLKS_PER_BIT must be at least 4");
  end

  uart_state_e          state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 bit_end;
  logic                 accept, shift_bit, stop_end;
  logic                 done_q;

  assign bit_end = (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.tx_start) state_next = START;
        START:   if (bit_end) state_next = DATA;
        DATA:    if (bit_end && bit_idx == 3'd7) state_next = STOP;
        STOP:    if (bit_end) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Line and busy are gated by en so dropping en forces the idle level at once.
  always_comb begin
    tx_line     = 1'b1;
    bus.tx_busy = 1'b0;
    accept      = 1'b0;
    shift_bit   = 1'b0;
    stop_end    = 1'b0;
    if (en) begin
      bus.tx_busy = (state != IDLE);
      accept      = (state == IDLE) && bus.tx_start;
      shift_bit   = (state == DATA) && bit_end;
      stop_end    = (state == STOP) && bit_end;
      case (state)
        START:   tx_line = 1'b0;
        DATA:    tx_line = shift_q[0];
        default: tx_line = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if (!en || state == IDLE || bit_end) cnt <= '0;
      else                                 cnt <= cnt + 1'b1;
      if (!en || state != DATA)                   bit_idx <= '0;
      else if (bit_end && bit_idx != 3'd7)        bit_idx <= bit_idx + 1'b1;
    end
  end

  // The byte is captured once at acceptance; later tx_data changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= stop_end;
      if (accept)         shift_q <= bus.tx_data;
      else if (shift_bit) shift_q <= {1'b1, shift_q[DATA_BITS-1:1]};
    end
  end

  assign bus.tx_done = done_q && en;

  uart8n1_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .rx_line      (rx_line),
    .rx_busy      (bus.rx_busy),
    .rx_done      (bus.rx_done),
    .rx_data      (bus.rx_data)
`ifdef UART_FRAME_ERR_EN
    ,
    .rx_frame_err (bus.rx_frame_err)
`endif
  );

endmodule

// File: tb/tb_uart8n1_top.sv
// -----------------------------------------------------------------------------
// tb_uart8n1_top
// Self-checking bench for uart8n1_top with a small CLKS_PER_BIT. Bytes sent in
// loopback are pushed to a scoreboard queue and popped when rx_done pulses.
// The TX waveform of every frame is compared cycle by cycle with the 8N1 frame.
// -----------------------------------------------------------------------------
module tb_uart8n1_top;
  import uart8n1_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic tx_line;
  logic rx_line;
  logic rx_drive;
  logic loop_sel;

  uart8n1_if bus ();

  int check_count     = 0;
  int pass_count      = 0;
  int rx_done_count   = 0;
  int frame_err_count = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] hello[6]   = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
  logic [7:0] pattern[8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h00, 8'hFF, 8'hAA, 8'h55};

  always #5 clk = ~clk;

  assign rx_line = loop_sel ? tx_line : rx_drive;

  uart8n1_top #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .bus     (bus),
    .tx_line (tx_line),
    .rx_line (rx_line)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    else
      pass_count++;
  endtask

  // Scoreboard side: every rx_done pops the next byte that was sent.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.rx_done === 1'b1) begin
      rx_done_count++;
      if (exp_q.size() > 0) begin
        exp_byte = exp_q.pop_front();
        checkOutput("rxData", bus.rx_data, exp_byte);
        last_rx = exp_byte;
      end
    end
  end

`ifdef UART_FRAME_ERR_EN
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.rx_frame_err === 1'b1) frame_err_count++;
  end
`endif

  // Sends one byte, checks latency, waveform and done pulse; optionally pokes
  // tx_start again mid-frame with different data.
  task automatic applyStimulus(input logic [7:0] data, input bit push, input bit poke);
    int         cycles;
    int         wave_err;
    bit         done_seen;
    logic [9:0] frame;
    frame     = {1'b1, data, 1'b0};
    wave_err  = 0;
    done_seen = 1'b0;
    cycles    = 0;
    @(negedge clk);
    bus.tx_start = 1'b1;
    bus.tx_data  = data;
    if (push) exp_q.push_back(data);
    while (!done_seen && cycles < 12 * CPB) begin
      @(negedge clk);
      cycles++;
      if (bus.tx_done === 1'b1) done_seen = 1'b1;
      else if (cycles <= 10 * CPB && tx_line !== frame[(cycles - 1) / CPB]) wave_err++;
      if (cycles == 1) begin
        bus.tx_start = 1'b0;
        bus.tx_data  = ~data;
      end
      if (poke && cycles == 3 * CPB) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h0F;
      end
      if (poke && cycles == 3 * CPB + 1) begin
        bus.tx_start = 1'b0;
        checkOutput("busyWhilePoked", bus.tx_busy, 1);
      end
    end
    checkOutput("txDoneSeen", done_seen, 1);
    checkOutput("txLatency", cycles, 10 * CPB + 1);
    checkOutput("txWave", wave_err, 0);
    checkOutput("txBusyAtDone", bus.tx_busy, 0);
    checkOutput("txLineAtDone", tx_line, 1);
    @(negedge clk);
    checkOutput("txDonePulse", bus.tx_done, 0);
  endtask

  task automatic driveRxFrame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drive = f[b];
      repeat (CPB) @(negedge clk);
    end
    rx_drive = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw;
    reset        = 1'b0;
    en           = 1'b0;
    loop_sel     = 1'b1;
    rx_drive     = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("rstTxLine", tx_line, 1);
    checkOutput("rstTxBusy", bus.tx_busy, 0);
    checkOutput("rstTxDone", bus.tx_done, 0);
    checkOutput("rstRxBusy", bus.rx_busy, 0);
    checkOutput("rstRxDone", bus.rx_done, 0);
    checkOutput("rstRxData", bus.rx_data, 8'h00);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("enOffTxLine", tx_line, 1);
    en = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idleTxLine", tx_line, 1);
    checkOutput("idleTxBusy", bus.tx_busy, 0);
    checkOutput("idleRxBusy", bus.rx_busy, 0);
    checkOutput("idleRxData", bus.rx_data, 8'h00);

    foreach (hello[i]) applyStimulus(hello[i], 1'b1, 1'b0);
    checkOutput("rxCountHello", rx_done_count, 6);
    foreach (pattern[i]) applyStimulus(pattern[i], 1'b1, 1'b0);
    checkOutput("rxCountPattern", rx_done_count, 14);

    // Mid-frame tx_start must not queue a second frame.
    applyStimulus(8'hAA, 1'b1, 1'b1);
    saw = 1'b0;
    repeat (12 * CPB) begin
      @(negedge clk);
      if (bus.tx_busy === 1'b1) saw = 1'b1;
    end
    checkOutput("noSecondFrame", saw, 0);
    checkOutput("rxCountPoke", rx_done_count, 15);

    // Short low glitch on rx_line.
    loop_sel = 1'b0;
    rx_drive = 1'b1;
    repeat (4) @(negedge clk);
    rx_drive = 1'b0;
    saw      = 1'b0;
    for (int i = 1; i <= 3 * CPB; i++) begin
      @(negedge clk);
      if (i == CPB / 4) rx_drive = 1'b1;
      if (bus.rx_busy === 1'b1) saw = 1'b1;
    end
    checkOutput("glitchSawBusy", saw, 1);
    checkOutput("glitchRxBusy", bus.rx_busy, 0);
    checkOutput("glitchRxCount", rx_done_count, 15);

    // Stop bit forced low.
    driveRxFrame(8'hC3, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    checkOutput("ferrRxCount", rx_done_count, 15);
    checkOutput("ferrRxData", bus.rx_data, last_rx);
    checkOutput("ferrRxBusy", bus.rx_busy, 0);
`ifdef UART_FRAME_ERR_EN
    checkOutput("ferrPulse", frame_err_count, 1);
`endif

    // Abort a frame by dropping en.
    loop_sel = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'h00;
    @(negedge clk);
    bus.tx_start = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    checkOutput("abortLineLow", tx_line, 0);
    checkOutput("abortBusyHigh", bus.tx_busy, 1);
    en = 1'b0;
    #1;
    checkOutput("abortLineHigh", tx_line, 1);
    checkOutput("abortBusyLow", bus.tx_busy, 0);
    saw = 1'b0;
    repeat (12 * CPB) begin
      @(negedge clk);
      if (bus.tx_done === 1'b1 || bus.rx_done === 1'b1) saw = 1'b1;
    end
    checkOutput("abortNoDone", saw, 0);
    en = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, 1'b0);

    checkOutput("rxCountFinal", rx_done_count, 16);
    checkOutput("scoreboardEmpty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
